// File: rtl/ib32bit_fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// ib32bit_fetch_buffer_if
// Bundles the fetch-address handshake, the flush, the program-load port and
// the instruction-delivery handshake of the fetch buffer.
//   master : the PC / decode / loader side (drives addresses, flush, writes,
//            instr_ready; observes addr_ready and the instruction head)
//   slave  : the fetch buffer itself
// Parameters: AWIDTH (fetch address width), DWIDTH (instruction width).
// ---------------------------------------------------------------------------
interface ib32bit_fetch_buffer_if #(
  parameter int AWIDTH = 6,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] addr_in;
  logic              addr_valid;
  logic              addr_ready;
  logic              flush;
  logic              prog_we;
  logic [AWIDTH-1:0] prog_addr;
  logic [DWIDTH-1:0] prog_data;
  logic [DWIDTH-1:0] instr_out;
  logic [AWIDTH-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output addr_in, addr_valid, flush, prog_we, prog_addr, prog_data,
           instr_ready,
    input  addr_ready, instr_out, instr_addr, instr_valid
  );

  modport slave (
    input  addr_in, addr_valid, flush, prog_we, prog_addr, prog_data,
           instr_ready,
    output addr_ready, instr_out, instr_addr, instr_valid
  );
endinterface

// File: rtl/ib32bit_fetch_buffer.sv
// ---------------------------------------------------------------------------
// ib32bit_fetch_buffer
// Instruction-fetch responder. Fetch addresses are accepted from the PC,
// looked up in an internal word-addressed instruction memory (one register
// stage), and the {instruction, address} pair is queued in a DEPTH-entry
// FIFO that feeds decode.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of ib32bit_fetch_buffer_if (fetch handshake, flush,
//            program-load port, instruction handshake)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid never depends on ready. addr_ready is a pure function of registers
// (count_q, rd_valid_q), so there is no combinational path from addr_valid
// or instr_ready to addr_ready.
// ---------------------------------------------------------------------------
module ib32bit_fetch_buffer #(
  parameter int AWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ib32bit_fetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Instruction memory: no reset, untouched by flush.
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

  // FIFO storage: contents are only meaningful below count_q, so no reset.
  logic [DWIDTH-1:0] fifo_data [DEPTH];
  logic [AWIDTH-1:0] fifo_addr [DEPTH];

  // Read stage
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;

  // FIFO control
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              accept;
  logic              push;
  logic              pop;
  logic [CW:0]       credit_used;

  // Entries already queued plus the one in the read stage must leave room,
  // which is what guarantees a push never meets a full FIFO.
  assign credit_used    = {1'b0, count_q} + {{CW{1'b0}}, rd_valid_q};
  assign bus.addr_ready = credit_used < (CW+1)'(DEPTH);

  assign bus.instr_valid = (count_q != '0);
  // Head is gated so the outputs read zero whenever the FIFO is empty.
  assign bus.instr_out   = bus.instr_valid ? fifo_data[rd_ptr_q] : '0;
  assign bus.instr_addr  = bus.instr_valid ? fifo_addr[rd_ptr_q] : '0;

  always_comb begin
    accept     = bus.addr_valid && bus.addr_ready && !bus.flush;
    push       = rd_valid_q && !bus.flush;
    pop        = bus.instr_valid && bus.instr_ready && !bus.flush;

    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = accept;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      // Combinational read of the pre-edge contents: a same-edge program
      // write to this address lands after, giving read-before-write.
      rd_data_d = mem[bus.addr_in];
      rd_addr_d = bus.addr_in;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Flush overrides everything: in-flight read, queue and any pop.
    if (bus.flush) begin
      rd_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= rd_data_q;
      fifo_addr[wr_ptr_q] <= rd_addr_q;
    end
  end

endmodule
